// File: rtl/alu_selftest_pkg.sv
// Shared types for the ALU self-test sequencer: opcodes, FSM states, the fixed
// vector table and the golden model the sequencer checks against.
package alu_selftest_pkg;

  typedef enum logic [2:0] {
    OpAdd = 3'd0,
    OpSub = 3'd1,
    OpShr = 3'd2,
    OpShl = 3'd3,
    OpAnd = 3'd4,
    OpOr  = 3'd5,
    OpXor = 3'd6
  } alu_op_e;

  typedef enum logic [2:0] {
    StIdle,
    StDrive,
    StSettle,
    StCheck,
    StDone
  } state_e;

  localparam int unsigned NUM_VEC = 28;

  typedef struct packed {
    alu_op_e    op;
    logic [3:0] a;
    logic [3:0] b;
  } vec_t;

  // Ascending range so the first listed entry is vector 0.
  localparam vec_t [0:NUM_VEC-1] VECTORS = {
    {OpAdd, 4'd15, 4'd15}, {OpAdd, 4'd0,  4'd0},  {OpAdd, 4'd5,  4'd3},  {OpAdd, 4'd10, 4'd1},
    {OpSub, 4'd8,  4'd15}, {OpSub, 4'd10, 4'd4},  {OpSub, 4'd8,  4'd8},  {OpSub, 4'd0,  4'd15},
    {OpShr, 4'd5,  4'd0},  {OpShr, 4'd10, 4'd0},  {OpShr, 4'd3,  4'd0},  {OpShr, 4'd15, 4'd0},
    {OpShl, 4'd3,  4'd0},  {OpShl, 4'd4,  4'd0},  {OpShl, 4'd12, 4'd0},  {OpShl, 4'd5,  4'd0},
    {OpAnd, 4'd0,  4'd15}, {OpAnd, 4'd3,  4'd1},  {OpAnd, 4'd8,  4'd12}, {OpAnd, 4'd4,  4'd2},
    {OpOr,  4'd0,  4'd15}, {OpOr,  4'd5,  4'd2},  {OpOr,  4'd10, 4'd3},  {OpOr,  4'd4,  4'd2},
    {OpXor, 4'd7,  4'd3},  {OpXor, 4'd8,  4'd1},  {OpXor, 4'd14, 4'd5},  {OpXor, 4'd3,  4'd2}
  };

  // Returns {y[31:0], n, z, c, v} for a w-bit ALU; operands must already fit in w bits.
  function automatic logic [35:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input alu_op_e op, input int unsigned w);
    logic [31:0] mask;
    logic [31:0] y;
    logic [32:0] sum;
    logic [4:0]  msb;
    logic [5:0]  cpos;
    logic        c;
    logic        v;
    mask = (w >= 32) ? 32'hffff_ffff : ((32'd1 << w) - 32'd1);
    msb  = 5'(w - 1);
    cpos = 6'(w);
    y    = '0;
    sum  = '0;
    c    = 1'b0;
    v    = 1'b0;
    case (op)
      OpAdd: begin
        sum = {1'b0, a} + {1'b0, b};
        y   = sum[31:0] & mask;
        c   = sum[cpos];
        v   = (a[msb] == b[msb]) && (y[msb] != a[msb]);
      end
      OpSub: begin
        y = (a - b) & mask;
        c = (a >= b);
        v = (a[msb] != b[msb]) && (y[msb] != a[msb]);
      end
      OpShr: begin
        y = a >> 1;
        c = a[0];
      end
      OpShl: begin
        y = (a << 1) & mask;
        c = a[msb];
      end
      OpAnd:   y = a & b;
      OpOr:    y = a | b;
      OpXor:   y = a ^ b;
      default: y = '0;
    endcase
    return {y, y[msb], (y == 32'd0), c, v};
  endfunction

endpackage

// File: rtl/alu_selftest.sv
// On-FPGA ALU self-test sequencer: plays the fixed vector table into the ALU, waits
// SETTLE cycles per vector, and scores the ALU result and flags against the golden model.
module alu_selftest
  import alu_selftest_pkg::*;
#(
  parameter int unsigned N      = 4,
  parameter int unsigned SETTLE = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [2:0]   alu_op,
  input  logic [N-1:0] alu_y,
  input  logic         alu_n,
  input  logic         alu_z,
  input  logic         alu_c,
  input  logic         alu_v,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [7:0]   fail_count,
  output logic [4:0]   fail_idx
);

  localparam int unsigned CntW    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [4:0]  LastIdx = 5'(NUM_VEC - 1);

  state_e          state_q, state_d;
  logic [4:0]      idx_q, idx_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [N-1:0]    a_q, a_d, b_q, b_d;
  alu_op_e         op_q, op_d;
  logic [7:0]      fail_count_q, fail_count_d;
  logic [4:0]      fail_idx_q, fail_idx_d;

  logic [4:0]      next_idx;
  vec_t            next_vec;
  logic [35:0]     exp_res;
  logic            mismatch;

  // Vector to load on leaving IDLE/DONE (index 0) or CHECK (the following index).
  assign next_idx = (state_q == StCheck && idx_q != LastIdx) ? idx_q + 5'd1 : 5'd0;
  assign next_vec = VECTORS[next_idx];

  // Operands held on the ALU are exactly vector[idx], so the model runs off them.
  assign exp_res  = alu_model(32'(a_q), 32'(b_q), op_q, N);
  assign mismatch = {32'(alu_y), alu_n, alu_z, alu_c, alu_v} != exp_res;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    fail_count_d = fail_count_q;
    fail_idx_d   = fail_idx_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d      = StDrive;
          idx_d        = 5'd0;
          fail_count_d = 8'd0;
          fail_idx_d   = 5'd0;
          a_d          = N'(next_vec.a);
          b_d          = N'(next_vec.b);
          op_d         = next_vec.op;
        end
      end
      StDrive: begin
        cnt_d   = CntW'(SETTLE - 1);
        state_d = StSettle;
      end
      StSettle: begin
        if (cnt_q == '0) state_d = StCheck;
        else             cnt_d   = cnt_q - CntW'(1);
      end
      StCheck: begin
        if (mismatch) begin
          if (fail_count_q == 8'd0)  fail_idx_d   = idx_q;
          if (fail_count_q != 8'hff) fail_count_d = fail_count_q + 8'd1;
        end
        if (idx_q == LastIdx) begin
          state_d = StDone;
        end else begin
          state_d = StDrive;
          idx_d   = next_idx;
          a_d     = N'(next_vec.a);
          b_d     = N'(next_vec.b);
          op_d    = next_vec.op;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      idx_q        <= 5'd0;
      cnt_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= OpAdd;
      fail_count_q <= 8'd0;
      fail_idx_q   <= 5'd0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      fail_count_q <= fail_count_d;
      fail_idx_q   <= fail_idx_d;
    end
  end

  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_op     = op_q;
  assign busy       = (state_q == StDrive) || (state_q == StSettle) || (state_q == StCheck);
  assign done       = (state_q == StDone);
  assign pass       = done && (fail_count_q == 8'd0);
  assign fail_count = fail_count_q;
  assign fail_idx   = fail_idx_q;

endmodule

// File: tb/tb_alu_selftest.sv
// Bench for alu_selftest: a behavioural 4-bit ALU with injectable faults, a scoreboard of
// expected operand sequences and run results, and a negedge monitor that scores them.
module tb_alu_selftest;

  localparam int N      = 4;
  localparam int S      = 2;
  localparam int NV     = 28;
  localparam int PERIOD = S + 2;

  localparam int VA[NV] = '{15, 0, 5, 10, 8, 10, 8, 0, 5, 10, 3, 15, 3, 4, 12, 5,
                            0, 3, 8, 4, 0, 5, 10, 4, 7, 8, 14, 3};
  localparam int VB[NV] = '{15, 0, 3, 1, 15, 4, 8, 15, 0, 0, 0, 0, 0, 0, 0, 0,
                            15, 1, 12, 2, 15, 2, 3, 2, 3, 1, 5, 2};

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] op;
  } tvec_t;

  typedef struct packed {
    logic [7:0] cnt;
    logic [4:0] idx;
    logic       pass;
  } tres_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [N-1:0] alu_a, alu_b, alu_y;
  logic [2:0]   alu_op;
  logic         alu_n, alu_z, alu_c, alu_v;
  logic         busy, done, pass;
  logic [7:0]   fail_count;
  logic [4:0]   fail_idx;

  int            n_cmp = 0;
  int            n_bad = 0;
  int            fault_mode = 0;
  logic [NV-1:0] fmask = '0;
  logic [7:0]    fxor = 8'd0;
  logic [7:0]    resp;
  tvec_t         exp_vec_q[$];
  tres_t         exp_res_q[$];

  always #5 clk = ~clk;

  alu_selftest #(.N(N), .SETTLE(S)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_y      (alu_y),
    .alu_n      (alu_n),
    .alu_z      (alu_z),
    .alu_c      (alu_c),
    .alu_v      (alu_v),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .fail_count (fail_count),
    .fail_idx   (fail_idx)
  );

  // Plain integer arithmetic: {y[3:0], n, z, c, v}.
  function automatic logic [7:0] golden(int a, int b, int op);
    int   y, r, sa, sb;
    logic c, v;
    sa = (a >= 8) ? a - 16 : a;
    sb = (b >= 8) ? b - 16 : b;
    y  = 0;
    c  = 1'b0;
    v  = 1'b0;
    case (op)
      0: begin y = (a + b) % 16; c = (a + b >= 16); r = sa + sb; v = (r > 7 || r < -8); end
      1: begin y = (a - b + 16) % 16; c = (a >= b); r = sa - sb; v = (r > 7 || r < -8); end
      2: begin y = a / 2; c = (a % 2 == 1); end
      3: begin y = (a * 2) % 16; c = (a >= 8); end
      4: y = a & b;
      5: y = a | b;
      6: y = a ^ b;
      default: y = 0;
    endcase
    return {4'(y), (y >= 8), (y == 0), c, v};
  endfunction

  // Bench ALU: golden behaviour plus the selected fault.
  function automatic logic [7:0] alu_resp(int a, int b, int op, int mode,
                                          logic [NV-1:0] mask, logic [7:0] x);
    logic [7:0] r;
    r = golden(a, b, op);
    if (mode == 1) r[2] = 1'b0;
    if (mode == 2 && op == 1) r[1] = ~r[1];
    if (mode == 3)
      for (int i = 0; i < NV; i++)
        if (mask[i] && VA[i] == a && VB[i] == b && i / 4 == op) r = r ^ x;
    return r;
  endfunction

  always_comb resp = alu_resp(int'(alu_a), int'(alu_b), int'(alu_op), fault_mode, fmask, fxor);
  assign {alu_y, alu_n, alu_z, alu_c, alu_v} = resp;

  task automatic check(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_zero(string pfx);
    check({pfx, "_alu_a"}, int'(alu_a), 0);
    check({pfx, "_alu_b"}, int'(alu_b), 0);
    check({pfx, "_alu_op"}, int'(alu_op), 0);
    check({pfx, "_busy"}, int'(busy), 0);
    check({pfx, "_done"}, int'(done), 0);
    check({pfx, "_pass"}, int'(pass), 0);
    check({pfx, "_fail_count"}, int'(fail_count), 0);
    check({pfx, "_fail_idx"}, int'(fail_idx), 0);
  endtask

  // Selects the ALU fault and queues what one full run must show.
  task automatic issue_run(int mode, logic [NV-1:0] mask, logic [7:0] x);
    int    cnt, first;
    tres_t r;
    cnt        = 0;
    first      = 0;
    fault_mode = mode;
    fmask      = mask;
    fxor       = x;
    for (int i = 0; i < NV; i++) begin
      exp_vec_q.push_back({4'(VA[i]), 4'(VB[i]), 3'(i / 4)});
      if (alu_resp(VA[i], VB[i], i / 4, mode, mask, x) != golden(VA[i], VB[i], i / 4)) begin
        if (cnt == 0) first = i;
        cnt++;
      end
    end
    r.cnt  = 8'(cnt);
    r.idx  = 5'(first);
    r.pass = (cnt == 0);
    exp_res_q.push_back(r);
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_done(string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      seen = done;
    end
    if (!seen) check({name, "_timeout"}, 0, 1);
  endtask

  // Monitor: scores every operand change and every rising done against the scoreboard.
  logic  busy_p = 1'b0;
  logic  done_p = 1'b0;
  int    cyc = 0;
  int    nvec = 0;
  tvec_t last = '0;

  always @(negedge clk) begin
    tvec_t got, ev;
    tres_t er;
    got = {alu_a, alu_b, alu_op};
    if (rst) begin
      busy_p = 1'b0;
      done_p = 1'b0;
      cyc    = 0;
      nvec   = 0;
    end else begin
      if (busy && !busy_p) begin
        cyc  = 0;
        nvec = 0;
      end else begin
        cyc++;
      end
      if (busy && (!busy_p || got != last)) begin
        if (exp_vec_q.size() == 0) begin
          check("unexpected_drive", int'(got), -1);
        end else begin
          ev = exp_vec_q.pop_front();
          check($sformatf("vec%0d_ops", nvec), int'(got), int'(ev));
          check($sformatf("vec%0d_time", nvec), cyc, nvec * PERIOD);
        end
        nvec++;
      end
      if (done && !done_p) begin
        check("done_time", cyc, NV * PERIOD);
        if (exp_res_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          er = exp_res_q.pop_front();
          check("res_fail_count", int'(fail_count), int'(er.cnt));
          check("res_fail_idx", int'(fail_idx), int'(er.idx));
          check("res_pass", int'(pass), int'(er.pass));
        end
      end
      busy_p = busy;
      done_p = done;
    end
    last = got;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int m;
    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    issue_run(0, '0, 8'd0);
    pulse_start();
    wait_done("run_good");

    issue_run(1, '0, 8'd0);
    pulse_start();
    wait_done("run_zstuck");

    issue_run(2, '0, 8'd0);
    pulse_start();
    wait_done("run_subc");

    for (int r = 0; r < 4; r++) begin
      m = $urandom_range(0, 3);
      repeat ($urandom_range(0, 5)) @(negedge clk);
      issue_run(m, NV'($urandom()), 8'($urandom_range(1, 255)));
      pulse_start();
      wait_done($sformatf("run_rand%0d", r));
    end

    // start held high: no restart until DONE, then DONE lasts one cycle.
    issue_run(1, '0, 8'd0);
    issue_run(1, '0, 8'd0);
    @(negedge clk) start = 1'b1;
    wait_done("held1");
    @(negedge clk);
    check("held_done_drop", int'(done), 0);
    check("held_restart_busy", int'(busy), 1);
    check("held_cleared_count", int'(fail_count), 0);
    check("held_cleared_idx", int'(fail_idx), 0);
    start = 1'b0;
    wait_done("held2");

    // Reset lands on edge E0+50.
    issue_run(0, '0, 8'd0);
    pulse_start();
    repeat (49) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_zero("midrst");
    #1;
    exp_vec_q.delete();
    exp_res_q.delete();
    rst = 1'b0;

    issue_run(0, '0, 8'd0);
    pulse_start();
    wait_done("after_rst");

    @(negedge clk);
    check("queues_drained", exp_vec_q.size() + exp_res_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_selftest.md
# alu_selftest

On-FPGA self-test sequencer for the N-bit ALU. It plays a fixed 28-entry vector list into the ALU's operand and opcode inputs. After a settle delay it samples the ALU's result and N/Z/C/V flags and compares them against an internal golden model. It reports pass/fail and a failure count, and sits between the board's start button (debounced upstream) and the ALU instance.

## Interface
Parameters:
- N, 4, operand/result width
- SETTLE, 2, wait cycles between driving a vector and checking it (≥1)

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  level-sampled; starts a run when the FSM is in IDLE or DONE
- alu_a  out  N  operand A to ALU (registered)
- alu_b  out  N  operand B to ALU (registered)
- alu_op  out  3  opcode to ALU (registered)
- alu_y  in  N  ALU result
- alu_n, alu_z, alu_c, alu_v  in  1 each  ALU flags
- busy  out  1  high in DRIVE/SETTLE/CHECK
- done  out  1  high in DONE
- pass  out  1  high in DONE when fail_count==0
- fail_count  out  8  mismatching vectors, saturates at 255
- fail_idx  out  5  index of first failing vector; 0 if none

## Operation
- Opcodes:
  - 0 ADD
  - 1 SUB (a−b)
  - 2 SHR by 1
  - 3 SHL by 1
  - 4 AND
  - 5 OR
  - 6 XOR
  - 7 unused, never issued
- Golden model, all arithmetic mod 2^N:
  - N = y[N−1]; Z = (y==0).
  - ADD: C = carry out; V = signed overflow (operand signs equal, result sign differs).
  - SUB: C = 1 when a ≥ b unsigned (no borrow); V = signed overflow (operand signs differ, result sign ≠ a's sign).
  - SHR: y = a>>1, C = a[0], V = 0.
  - SHL: y = a<<1, C = a[N−1], V = 0.
  - AND/OR/XOR: C = V = 0.
- Vector list (a,b,op), index 0..27:
  - ADD: (15,15) (0,0) (5,3) (10,1)
  - SUB: (8,15) (10,4) (8,8) (0,15)
  - SHR: (5,0) (10,0) (3,0) (15,0)
  - SHL: (3,0) (4,0) (12,0) (5,0)
  - AND: (0,15) (3,1) (8,12) (4,2)
  - OR: (0,15) (5,2) (10,3) (4,2)
  - XOR: (7,3) (8,1) (14,5) (3,2)
- A vector mismatches if any of y, N, Z, C, V differ from the model. Each mismatch adds one to fail_count; fail_idx is written on the first mismatch only.
- FSM states and transitions:
  - IDLE: start → DRIVE with idx=0; fail_count and fail_idx cleared.
  - DRIVE (1 cycle): alu_a/b/op hold vector[idx]; load settle counter with SETTLE−1 → SETTLE.
  - SETTLE: counter decrements; counter==0 → CHECK.
  - CHECK (1 cycle): compare sampled ALU outputs with the model of vector[idx]. If idx==27 → DONE; else idx+1, load the next vector → DRIVE.
  - DONE: holds all results. start → restart exactly as from IDLE.
- start is ignored while busy.

## Timing
- Reset values: alu_a=0, alu_b=0, alu_op=0, busy=0, done=0, pass=0, fail_count=0, fail_idx=0; state IDLE, idx=0.
- Registered outputs change on the edge that enters DRIVE.
- Counting from edge E0, the edge that samples start:
  - vector k enters DRIVE at edge E0 + k·(SETTLE+2);
  - vector k is checked in the cycle after edge E0 + k·(SETTLE+2) + SETTLE + 1;
  - done rises after edge E0 + 28·(SETTLE+2), which is edge 112 for SETTLE=2.
- Operands stay stable for SETTLE+2 cycles per vector. The ALU must settle within SETTLE cycles.
- Reset mid-run: on the next edge, all outputs return to reset values and any run in progress is abandoned.
- start and rst on the same edge: rst wins.

## Structure
- Package alu_selftest_pkg holds:
  - opcode enum alu_op_e;
  - NUM_VEC=28;
  - packed constant vector array;
  - fsm state enum;
  - function alu_model(a,b,op) returning {y,n,z,c,v}.
- No sub-module. The FSM, counters and comparator live in alu_selftest.

## Test plan
- Reset, then bench-modelled correct ALU, start pulse at E0 → done=1 and pass=1 after edge E0+112; fail_count=0, fail_idx=0.
- Output sequencing → alu_a/b/op = 15/15/0 after E0; 0/0/0 after E0+4; 5/0/2 after E0+32; 3/2/6 after E0+108.
- Bench ALU with Z stuck at 0 → fail_count=4 (vectors 1, 6, 16, 19), fail_idx=1, pass=0.
- Bench ALU with SUB C inverted → fail_count=4 (vectors 4–7), fail_idx=4.
- start held high throughout the run → no restart until DONE; done visible for one cycle before the restart clears the results.
- rst at E0+50 → next edge all outputs 0, busy=0. A new start then runs the full sequence, with pass=1 after 112 more edges.
